// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for the programmable kitchen timer: state encodings,
// BCD digit limits and small binary/BCD conversion helpers used when the
// minutes value is adjusted as a whole number.
package timer_pkg;

  typedef enum logic [1:0] {
    SETTING = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    BEEPING = 2'd3
  } state_t;

  // Highest value each BCD digit reaches before it wraps or borrows.
  localparam logic [3:0] SECS_LIMIT     = 4'd9;
  localparam logic [3:0] TEN_SECS_LIMIT = 4'd5;
  localparam logic [3:0] MINS_LIMIT     = 4'd9;

  // Two BCD digits (tens, ones) to a binary value 0..99.
  function automatic logic [6:0] from_bcd(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  // Binary value 0..99 to {tens, ones} BCD digits.
  function automatic logic [7:0] to_bcd(input logic [6:0] bin);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(bin / 7'd10);
    ones = 4'(bin % 7'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
// One-second prescaler. Counts enabled clock cycles 0..TICK_DIV-1 and
// raises tick during the cycle the count sits at TICK_DIV-1; the count then
// returns to 0 on that edge. While disabled the count holds.
// Ports:
//   CLK    - clock, posedge
//   RESET  - synchronous active-high reset, count to 0
//   clear  - synchronous clear of the count (wins over enable)
//   enable - advance the count this cycle
//   tick   - one-cycle pulse at the end of each TICK_DIV period
module tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // tick is gated by enable so a held prescaler sitting at LAST cannot fire.
  assign tick = enable && (count == LAST);

  // Prescaler register: clear and reset restart the period, enable advances it.
  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/prog_timer.sv
// prog_timer
// Programmable countdown timer / stopwatch with BCD display digits.
// Ports:
//   CLK, RESET                         - clock and synchronous active-high reset
//   s_up, s_dn, s_cancel,
//   s_start_stop, s_mode               - single-cycle debounced button pulses
//   secs, ten_secs, mins, ten_mins     - registered BCD time digits
//   count_up                           - 0 countdown, 1 stopwatch
//   state_o                            - current state encoding
//   alarm_on                           - buzzer enable
module prog_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int MAX_MINS   = 99,
  parameter int ALARM_SECS = 30
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       s_up,
  input  logic       s_dn,
  input  logic       s_cancel,
  input  logic       s_start_stop,
  input  logic       s_mode,
  output logic [3:0] secs,
  output logic [3:0] ten_secs,
  output logic [3:0] mins,
  output logic [3:0] ten_mins,
  output logic       count_up,
  output logic [1:0] state_o,
  output logic       alarm_on
);

  localparam logic [6:0] MAX_M = 7'(MAX_MINS);
  localparam int BW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(ALARM_SECS - 1);

  state_t        state, state_n;
  logic [3:0]    secs_n, ten_secs_n, mins_n, ten_mins_n;
  logic          count_up_n, alarm_n;
  logic [6:0]    stored_mins, stored_n;
  logic [BW-1:0] beep_cnt, beep_n;
  logic [6:0]    cur_mins;
  logic [7:0]    rst_bcd;
  logic          tick, tick_en, tick_clr;
  logic          cd_end, sw_end;

  // The prescaler runs while counting or beeping; a stop or cancel press
  // freezes it in the same cycle so no tick slips through on that edge.
  assign tick_en  = ((state == RUNNING) && !s_cancel && !s_start_stop) || (state == BEEPING);
  assign tick_clr = ((state == SETTING) && s_start_stop) || ((state != SETTING) && s_cancel);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (tick_clr),
    .enable (tick_en),
    .tick   (tick)
  );

  assign cur_mins = from_bcd(ten_mins, mins);
  assign rst_bcd  = to_bcd(count_up ? 7'd0 : stored_mins);
  assign cd_end   = (ten_mins == 4'd0) && (mins == 4'd0) && (ten_secs == 4'd0) && (secs <= 4'd1);
  assign sw_end   = (cur_mins == MAX_M) && (ten_secs == TEN_SECS_LIMIT) && (secs == SECS_LIMIT);
  assign state_o  = state;

  // Next-state and next-time logic. Everything defaults to holding; each
  // state then applies its button priority and the tick arithmetic.
  always_comb begin
    state_n    = state;
    count_up_n = count_up;
    alarm_n    = alarm_on;
    stored_n   = stored_mins;
    beep_n     = beep_cnt;
    secs_n     = secs;
    ten_secs_n = ten_secs;
    mins_n     = mins;
    ten_mins_n = ten_mins;
    case (state)
      SETTING: begin
        if (s_start_stop) begin
          if (!count_up) stored_n = cur_mins;
          state_n = RUNNING;
        end else if (s_mode) begin
          count_up_n = !count_up;
          {ten_mins_n, mins_n} = count_up ? to_bcd(stored_mins) : 8'h00;
          ten_secs_n = 4'd0;
          secs_n     = 4'd0;
        end else if (!count_up && (s_up ^ s_dn)) begin
          if (s_up) {ten_mins_n, mins_n} = to_bcd((cur_mins == MAX_M) ? 7'd1 : cur_mins + 7'd1);
          else      {ten_mins_n, mins_n} = to_bcd((cur_mins == 7'd1) ? MAX_M : cur_mins - 7'd1);
          ten_secs_n = 4'd0;
          secs_n     = 4'd0;
        end
      end
      RUNNING: begin
        if (s_cancel) begin
          {ten_mins_n, mins_n} = rst_bcd;
          ten_secs_n = 4'd0;
          secs_n     = 4'd0;
          state_n    = SETTING;
        end else if (s_start_stop) begin
          state_n = PAUSED;
        end else if (tick) begin
          if (!count_up) begin
            if (cd_end) begin
              secs_n  = 4'd0;
              alarm_n = 1'b1;
              beep_n  = '0;
              state_n = BEEPING;
            end else if (secs != 4'd0) begin
              secs_n = secs - 4'd1;
            end else begin
              secs_n = SECS_LIMIT;
              if (ten_secs != 4'd0) begin
                ten_secs_n = ten_secs - 4'd1;
              end else begin
                ten_secs_n = TEN_SECS_LIMIT;
                if (mins != 4'd0) begin
                  mins_n = mins - 4'd1;
                end else begin
                  mins_n     = MINS_LIMIT;
                  ten_mins_n = ten_mins - 4'd1;
                end
              end
            end
          end else begin
            if (sw_end) begin
              alarm_n = 1'b1;
              beep_n  = '0;
              state_n = BEEPING;
            end else if (secs != SECS_LIMIT) begin
              secs_n = secs + 4'd1;
            end else begin
              secs_n = 4'd0;
              if (ten_secs != TEN_SECS_LIMIT) begin
                ten_secs_n = ten_secs + 4'd1;
              end else begin
                ten_secs_n = 4'd0;
                if (mins != MINS_LIMIT) begin
                  mins_n = mins + 4'd1;
                end else begin
                  mins_n     = 4'd0;
                  ten_mins_n = ten_mins + 4'd1;
                end
              end
            end
          end
        end
      end
      PAUSED: begin
        if (s_cancel) begin
          {ten_mins_n, mins_n} = rst_bcd;
          ten_secs_n = 4'd0;
          secs_n     = 4'd0;
          state_n    = SETTING;
        end else if (s_start_stop) begin
          state_n = RUNNING;
        end
      end
      BEEPING: begin
        if (s_cancel || (tick && (beep_cnt == BEEP_LAST))) begin
          {ten_mins_n, mins_n} = rst_bcd;
          ten_secs_n = 4'd0;
          secs_n     = 4'd0;
          alarm_n    = 1'b0;
          beep_n     = '0;
          state_n    = SETTING;
        end else if (tick) begin
          beep_n = beep_cnt + BW'(1);
        end
      end
      default: state_n = SETTING;
    endcase
  end

  // State and output registers; reset lands on countdown mode at 01:00.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= SETTING;
      count_up    <= 1'b0;
      alarm_on    <= 1'b0;
      stored_mins <= 7'd1;
      beep_cnt    <= '0;
      secs        <= 4'd0;
      ten_secs    <= 4'd0;
      mins        <= 4'd1;
      ten_mins    <= 4'd0;
    end else begin
      state       <= state_n;
      count_up    <= count_up_n;
      alarm_on    <= alarm_n;
      stored_mins <= stored_n;
      beep_cnt    <= beep_n;
      secs        <= secs_n;
      ten_secs    <= ten_secs_n;
      mins        <= mins_n;
      ten_mins    <= ten_mins_n;
    end
  end

endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer
// Drives two prog_timer instances (MAX_MINS 99 and 1) with identical button
// pulses and compares both every cycle against a reference model that keeps
// time as a plain count of seconds, plus directed constant checks.
module tb_prog_timer;

  localparam int TD = 4;
  localparam int AS = 2;

  logic CLK = 1'b0;
  logic RESET, s_up, s_dn, s_cancel, s_start_stop, s_mode;

  logic [3:0] sc0, ts0, mn0, tm0, sc1, ts1, mn1, tm1;
  logic       cu0, al0, cu1, al1;
  logic [1:0] st0, st1;

  int checkCount = 0;
  int errCount   = 0;

  typedef struct {
    int st;
    bit cu;
    int t;
    int stored;
    int pre;
    int beep;
    bit alarm;
  } mdl_t;

  mdl_t m0, m1;

  always #5 CLK = ~CLK;

  prog_timer #(.TICK_DIV(TD), .MAX_MINS(99), .ALARM_SECS(AS)) dut0 (
    .CLK(CLK), .RESET(RESET), .s_up(s_up), .s_dn(s_dn), .s_cancel(s_cancel),
    .s_start_stop(s_start_stop), .s_mode(s_mode),
    .secs(sc0), .ten_secs(ts0), .mins(mn0), .ten_mins(tm0),
    .count_up(cu0), .state_o(st0), .alarm_on(al0)
  );

  prog_timer #(.TICK_DIV(TD), .MAX_MINS(1), .ALARM_SECS(AS)) dut1 (
    .CLK(CLK), .RESET(RESET), .s_up(s_up), .s_dn(s_dn), .s_cancel(s_cancel),
    .s_start_stop(s_start_stop), .s_mode(s_mode),
    .secs(sc1), .ten_secs(ts1), .mins(mn1), .ten_mins(tm1),
    .count_up(cu1), .state_o(st1), .alarm_on(al1)
  );

  // Reference model: one clock edge of behaviour from the written rules.
  function automatic mdl_t step(mdl_t m, int maxm, bit rst, bit up, bit dn,
                                bit cancel, bit ss, bit mode);
    mdl_t r;
    bit   tk;
    int   mm;
    int   rstT;
    r    = m;
    rstT = m.cu ? 0 : m.stored * 60;
    if (rst) begin
      r.st = 0; r.cu = 0; r.t = 60; r.stored = 1; r.pre = 0; r.beep = 0; r.alarm = 0;
      return r;
    end
    case (m.st)
      0: begin
        if (ss) begin
          if (!m.cu) r.stored = m.t / 60;
          r.pre = 0;
          r.st  = 1;
        end else if (mode) begin
          r.cu = !m.cu;
          r.t  = r.cu ? 0 : m.stored * 60;
        end else if (!m.cu && (up != dn)) begin
          mm = m.t / 60;
          if (up) mm = (mm == maxm) ? 1 : mm + 1;
          else    mm = (mm == 1) ? maxm : mm - 1;
          r.t = mm * 60;
        end
      end
      1: begin
        if (cancel) begin
          r.t = rstT; r.st = 0; r.pre = 0;
        end else if (ss) begin
          r.st = 2;
        end else begin
          tk    = (m.pre == TD - 1);
          r.pre = tk ? 0 : m.pre + 1;
          if (tk) begin
            if (!m.cu) begin
              if (m.t <= 1) begin r.t = 0; r.alarm = 1; r.beep = 0; r.st = 3; end
              else r.t = m.t - 1;
            end else begin
              if (m.t == maxm * 60 + 59) begin r.alarm = 1; r.beep = 0; r.st = 3; end
              else r.t = m.t + 1;
            end
          end
        end
      end
      2: begin
        if (cancel) begin
          r.t = rstT; r.st = 0; r.pre = 0;
        end else if (ss) begin
          r.st = 1;
        end
      end
      default: begin
        tk = (m.pre == TD - 1);
        if (cancel || (tk && m.beep == AS - 1)) begin
          r.t = rstT; r.st = 0; r.pre = 0; r.beep = 0; r.alarm = 0;
        end else begin
          r.pre = tk ? 0 : m.pre + 1;
          if (tk) r.beep = m.beep + 1;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] expectOf(mdl_t m);
    int mm;
    int ss;
    mm = m.t / 60;
    ss = m.t % 60;
    return {12'd0, 2'(m.st), m.cu, m.alarm, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of button pulses, advance both models, compare both DUTs.
  task automatic applyStimulus(input bit rst, input bit up, input bit dn,
                               input bit cancel, input bit ss, input bit mode);
    RESET = rst; s_up = up; s_dn = dn; s_cancel = cancel; s_start_stop = ss; s_mode = mode;
    @(posedge CLK);
    m0 = step(m0, 99, rst, up, dn, cancel, ss, mode);
    m1 = step(m1, 1, rst, up, dn, cancel, ss, mode);
    #1;
    checkOutput("model_dut0", {12'd0, st0, cu0, al0, tm0, mn0, ts0, sc0}, expectOf(m0));
    checkOutput("model_dut1", {12'd0, st1, cu1, al1, tm1, mn1, ts1, sc1}, expectOf(m1));
    RESET = 0; s_up = 0; s_dn = 0; s_cancel = 0; s_start_stop = 0; s_mode = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int r;
    RESET = 0; s_up = 0; s_dn = 0; s_cancel = 0; s_start_stop = 0; s_mode = 0;
    m0 = '{default: 0};
    m1 = '{default: 0};
    #2;

    $display("[TB] reset state");
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset_time", {16'd0, tm0, mn0, ts0, sc0}, 32'h0100);
    checkOutput("reset_state", {30'd0, st0}, 32'd0);
    checkOutput("reset_alarm_mode", {30'd0, al0, cu0}, 32'd0);

    $display("[TB] minute setting wrap");
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("dn_wrap_98", {24'd0, tm0, mn0}, 32'h98);
    checkOutput("dn_wrap_max1", {24'd0, tm1, mn1}, 32'h01);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("up_dn_same", {16'd0, tm0, mn0, ts0, sc0}, 32'h9800);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("up_wrap_1", {16'd0, tm0, mn0, ts0, sc0}, 32'h0100);

    $display("[TB] one minute countdown");
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(4);
    checkOutput("first_tick", {16'd0, tm0, mn0, ts0, sc0}, 32'h0059);
    idle(236);
    checkOutput("cd_end_time", {16'd0, tm0, mn0, ts0, sc0}, 32'h0000);
    checkOutput("cd_end_beep", {29'd0, st0, al0}, {29'd0, 2'd3, 1'b1});
    idle(7);
    checkOutput("beep_hold", {30'd0, st0}, 32'd3);
    idle(1);
    checkOutput("auto_return", {13'd0, st0, al0, tm0, mn0, ts0, sc0}, 32'h0100);

    $display("[TB] pause and resume");
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(82);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(20);
    checkOutput("paused_hold", {14'd0, st0, tm0, mn0, ts0, sc0}, {14'd0, 2'd2, 16'h0040});
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(1);
    checkOutput("resume_no_tick", {16'd0, tm0, mn0, ts0, sc0}, 32'h0040);
    idle(1);
    checkOutput("resume_tick", {16'd0, tm0, mn0, ts0, sc0}, 32'h0039);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("cancel_run", {14'd0, st0, tm0, mn0, ts0, sc0}, 32'h0100);

    $display("[TB] cancel beats start_stop");
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(10);
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("cancel_prio", {14'd0, st0, tm0, mn0, ts0, sc0}, 32'h0300);

    $display("[TB] stopwatch to limit");
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("sw_load", {15'd0, cu0, tm0, mn0, ts0, sc0}, 32'h10000);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(476);
    checkOutput("sw_159", {14'd0, st1, tm1, mn1, ts1, sc1}, {14'd0, 2'd1, 16'h0159});
    idle(4);
    checkOutput("sw_limit_beep", {13'd0, st1, al1, tm1, mn1, ts1, sc1}, {13'd0, 2'd3, 1'b1, 16'h0159});
    checkOutput("sw_past_limit", {16'd0, tm0, mn0, ts0, sc0}, 32'h0200);
    idle(3);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("sw_cancel", {13'd0, st1, al1, tm1, mn1, ts1, sc1}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("cd_reload", {15'd0, cu0, tm0, mn0, ts0, sc0}, 32'h0300);

    $display("[TB] reset during beeping");
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(241);
    checkOutput("pre_reset_beep", {31'd0, al0}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset_in_beep", {13'd0, st0, al0, tm0, mn0, ts0, sc0}, 32'h0100);

    $display("[TB] random stimulus");
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 4)  applyStimulus(0, 1, 0, 0, 0, 0);
      else if (r < 8)  applyStimulus(0, 0, 1, 0, 0, 0);
      else if (r < 9)  applyStimulus(0, 1, 1, 0, 0, 0);
      else if (r < 11) applyStimulus(0, 0, 0, 0, 0, 1);
      else if (r < 15) applyStimulus(0, 0, 0, 0, 1, 0);
      else if (r < 17) applyStimulus(0, 0, 0, 1, 0, 0);
      else if (r < 18) applyStimulus(0, 0, 0, 1, 1, 0);
      else if (r < 19 && ($urandom_range(0, 3) == 0)) applyStimulus(1, 0, 0, 0, 0, 0);
      else             applyStimulus(0, 0, 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
